controlvga_top: RTL and testbench

// - Top-level VGA controller: 640x480@60Hz timing from a 50 MHz Clock; fills the visible area with one RGB332 colour.
// - The colour is user-adjustable: TC+Up/Down steps the hue through an 8-entry palette; Lp+Up/Down steps brightness.
// - Drives the board VGA connector directly (3-bit R, 3-bit G, 2-bit B, active-low syncs).

---
 rtl/controlvga_top.sv | 166 ++++++++++++++++
 tb/tb_controlvga_top.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/controlvga_top.sv
// controlvga_top
//   VGA controller that generates 640x480@60Hz timing from a 50 MHz clock.
//   It fills the visible area with a single RGB332 colour. Up/Down together
//   with TC step the hue through an 8-entry palette. Up/Down together with Lp
//   step the brightness level (0..3).
// Ports
//   Clock  : 50 MHz system clock; all logic runs on its rising edge
//   reset  : asynchronous reset, active low
//   Up     : increment request (asynchronous button level)
//   Down   : decrement request (asynchronous button level)
//   TC     : Up/Down act on the hue
//   Lp     : Up/Down act on the brightness level
//   Rojo   : 3-bit red
//   Verde  : 3-bit green
//   Azul   : 2-bit blue
//   Hsinc  : horizontal sync, active low
//   Vsinc  : vertical sync, active low
module controlvga_top #(
  parameter int         H_VIS     = 640,
  parameter int         H_FP      = 16,
  parameter int         H_SYNC    = 96,
  parameter int         H_BP      = 48,
  parameter int         V_VIS     = 480,
  parameter int         V_FP      = 10,
  parameter int         V_SYNC    = 2,
  parameter int         V_BP      = 33,
  parameter logic [1:0] LEVEL_RST = 2'd3
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       Up,
  input  logic       Down,
  input  logic       TC,
  input  logic       Lp,
  output logic [1:0] Azul,
  output logic [2:0] Verde,
  output logic [2:0] Rojo,
  output logic       Hsinc,
  output logic       Vsinc
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_VIS);
  localparam logic [HW-1:0] H_SS   = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_VIS);
  localparam logic [VW-1:0] V_SS   = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_VIS + V_FP + V_SYNC - 1);

  logic          pix_en;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [3:0]    sync1, sync2;
  logic          up_prev, down_prev;
  logic [2:0]    hue;
  logic [1:0]    level;
  logic [2:0]    pal_r, pal_g;
  logic [1:0]    pal_b;
  logic [1:0]    shift;
  logic          up_evt, down_evt, tc_s, lp_s, active;

  // Divide the clock by two to get the 25 MHz pixel rate. The horizontal
  // counter wraps at the end of each line and then advances the line counter.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      pix_en <= 1'b0;
      h      <= '0;
      v      <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (h == H_LAST) begin
          h <= '0;
          v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end
    end
  end

  // Two-flop synchronisers for the buttons. The previous synchronised
  // Up/Down levels are kept so that only a rising edge counts as a step.
  // Holding a button therefore never repeats.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      sync1     <= '0;
      sync2     <= '0;
      up_prev   <= 1'b0;
      down_prev <= 1'b0;
    end else begin
      sync1     <= {Up, Down, TC, Lp};
      sync2     <= sync1;
      up_prev   <= sync2[3];
      down_prev <= sync2[2];
    end
  end

  assign up_evt   = sync2[3] & ~up_prev;
  assign down_evt = sync2[2] & ~down_prev;
  assign tc_s     = sync2[1];
  assign lp_s     = sync2[0];

  // A simultaneous Up and Down edge cancels out. TC has priority over Lp.
  // Hue wraps modulo 8, while the level saturates at 0 and 3.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      hue   <= 3'd0;
      level <= LEVEL_RST;
    end else if (up_evt ^ down_evt) begin
      if (tc_s) begin
        hue <= up_evt ? hue + 3'd1 : hue - 3'd1;
      end else if (lp_s) begin
        if (up_evt && level != 2'd3)
          level <= level + 2'd1;
        else if (down_evt && level != 2'd0)
          level <= level - 2'd1;
      end
    end
  end

  // Palette lookup.
  always_comb begin
    {pal_r, pal_g, pal_b} = 8'd0;
    case (hue)
      3'd0: {pal_r, pal_g, pal_b} = {3'd7, 3'd7, 2'd3};
      3'd1: {pal_r, pal_g, pal_b} = {3'd7, 3'd0, 2'd0};
      3'd2: {pal_r, pal_g, pal_b} = {3'd0, 3'd7, 2'd0};
      3'd3: {pal_r, pal_g, pal_b} = {3'd0, 3'd0, 2'd3};
      3'd4: {pal_r, pal_g, pal_b} = {3'd7, 3'd7, 2'd0};
      3'd5: {pal_r, pal_g, pal_b} = {3'd0, 3'd7, 2'd3};
      3'd6: {pal_r, pal_g, pal_b} = {3'd7, 3'd0, 2'd3};
      default: {pal_r, pal_g, pal_b} = {3'd3, 3'd3, 2'd1};
    endcase
  end

  // Dimming is a logical right shift. Level 3 leaves the colour unshifted,
  // and level 0 shifts every channel down to zero.
  assign shift  = 2'd3 - level;
  assign active = (h < H_ACT) && (v < V_ACT);

  // All outputs are registered so that the connector sees glitch-free
  // levels, one clock behind the counters.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      Hsinc <= 1'b1;
      Vsinc <= 1'b1;
      Rojo  <= 3'd0;
      Verde <= 3'd0;
      Azul  <= 2'd0;
    end else begin
      Hsinc <= ~((h >= H_SS) && (h <= H_SE));
      Vsinc <= ~((v >= V_SS) && (v <= V_SE));
      Rojo  <= active ? (pal_r >> shift) : 3'd0;
      Verde <= active ? (pal_g >> shift) : 3'd0;
      Azul  <= active ? (pal_b >> shift) : 2'd0;
    end
  end

endmodule

// File: tb/tb_controlvga_top.sv
// tb_controlvga_top
//   Testbench for controlvga_top. It uses shortened video timing so that
//   whole frames fit into a short run. Expected outputs come from a
//   position formula: the pixel index is derived from the number of clocks
//   since reset. Hue and level are tracked by an abstract button model.
module tb_controlvga_top;

  localparam int HV = 16, HF = 2, HS = 4, HB = 3;
  localparam int VV = 6,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic Clock = 1'b0;
  logic reset = 1'b0;
  logic up = 1'b0, down = 1'b0, tc = 1'b0, lp = 1'b0;
  logic [1:0] Azul;
  logic [2:0] Verde, Rojo;
  logic Hsinc, Vsinc;

  int checks = 0;
  int errors = 0;
  int n = 0;
  int hue_m = 0;
  int lvl_m = 3;
  int pal_r [8] = '{7, 7, 0, 0, 7, 0, 7, 3};
  int pal_g [8] = '{7, 0, 7, 0, 7, 7, 0, 3};
  int pal_b [8] = '{3, 0, 0, 3, 0, 3, 3, 1};

  controlvga_top #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .LEVEL_RST(2'd3)
  ) dut (
    .Clock(Clock), .reset(reset), .Up(up), .Down(down), .TC(tc), .Lp(lp),
    .Azul(Azul), .Verde(Verde), .Rojo(Rojo), .Hsinc(Hsinc), .Vsinc(Vsinc)
  );

  always #10 Clock = ~Clock;

  // Count of rising edges since reset was released.
  always @(posedge Clock or negedge reset) begin
    if (!reset) n <= 0;
    else        n <= n + 1;
  end

  // Expected {Hsinc, Vsinc, R, G, B} after k clock edges.
  function automatic logic [9:0] exp_out(int k, int hue, int lvl);
    int p, h, v, r, g, b;
    logic hs, vs;
    if (k == 0) return 10'b11_000_000_00;
    p  = ((k - 1) / 2) % FRAME;
    h  = p % HT;
    v  = p / HT;
    hs = !(h >= HV + HF && h < HV + HF + HS);
    vs = !(v >= VV + VF && v < VV + VF + VS);
    r = 0; g = 0; b = 0;
    if (h < HV && v < VV) begin
      r = pal_r[hue] >> (3 - lvl);
      g = pal_g[hue] >> (3 - lvl);
      b = pal_b[hue] >> (3 - lvl);
    end
    return {hs, vs, 3'(r), 3'(g), 2'(b)};
  endfunction

  // Abstract effect of one button press.
  task automatic model_step(input bit u, input bit d, input bit t, input bit l);
    if (u != d) begin
      if (t)      hue_m = (hue_m + (u ? 1 : 7)) % 8;
      else if (l) lvl_m = u ? ((lvl_m < 3) ? lvl_m + 1 : 3)
                            : ((lvl_m > 0) ? lvl_m - 1 : 0);
    end
  endtask

  // Drive one button press: the selects settle first, and Up/Down are
  // released before the selects.
  task automatic applyStimulus(input bit u, input bit d, input bit t,
                               input bit l, input int len);
    @(negedge Clock); tc = t; lp = l;
    repeat (3) @(negedge Clock);
    up = u; down = d;
    repeat (len) @(negedge Clock);
    up = 0; down = 0;
    repeat (4) @(negedge Clock);
    tc = 0; lp = 0;
    repeat (3) @(negedge Clock);
  endtask

  task automatic test_reset;
    logic [9:0] obs;
    reset = 0;
    repeat (3) @(negedge Clock);
    obs = {Hsinc, Vsinc, Rojo, Verde, Azul};
    checks++;
    if (obs !== 10'b11_000_000_00) begin
      errors++;
      $display("[TB] FAIL reset_state got=%b want=%b", obs, 10'b11_000_000_00);
    end
    reset = 1;
  endtask

  task automatic test_frame;
    logic [9:0] obs, ex;
    for (int c = 0; c < 2 * FRAME + 40; c++) begin
      @(negedge Clock);
      obs = {Hsinc, Vsinc, Rojo, Verde, Azul};
      ex  = exp_out(n, hue_m, lvl_m);
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("[TB] FAIL frame n=%0d got=%b want=%b", n, obs, ex);
      end
    end
  endtask

  task automatic test_latency;
    logic [9:0] obs, ex;
    int p, guard;
    tc = 1;
    repeat (3) @(negedge Clock);
    guard = 0;
    do begin
      @(negedge Clock);
      p = ((n + 3) / 2) % FRAME;
      guard++;
    end while (!((p % HT) < HV - 4 && (p / HT) < VV) && guard < 2000);
    checks++;
    if (guard >= 2000) begin
      errors++;
      $display("[TB] FAIL latency_align got=timeout want=visible");
    end
    up = 1;
    model_step(1, 0, 1, 0);
    repeat (4) @(posedge Clock);
    @(negedge Clock);
    obs = {Hsinc, Vsinc, Rojo, Verde, Azul};
    ex  = exp_out(n, hue_m, lvl_m);
    checks++;
    if (obs !== ex) begin
      errors++;
      $display("[TB] FAIL latency got=%b want=%b", obs, ex);
    end
    up = 0;
    repeat (4) @(negedge Clock);
    tc = 0;
    repeat (3) @(negedge Clock);
  endtask

  task automatic test_hold;
    logic [9:0] obs, ex;
    tc = 1;
    repeat (3) @(negedge Clock);
    up = 1;
    model_step(1, 0, 1, 0);
    repeat (6) @(negedge Clock);
    for (int c = 0; c < 60; c++) begin
      @(negedge Clock);
      obs = {Hsinc, Vsinc, Rojo, Verde, Azul};
      ex  = exp_out(n, hue_m, lvl_m);
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("[TB] FAIL hold n=%0d got=%b want=%b", n, obs, ex);
      end
    end
    up = 0;
    repeat (4) @(negedge Clock);
    tc = 0;
    repeat (3) @(negedge Clock);
  endtask

  task automatic test_directed;
    // Each entry is {up, down, tc, lp}.
    logic [3:0] tbl [12] = '{4'b1010, 4'b1001, 4'b0101, 4'b0101, 4'b0110,
                             4'b0110, 4'b1011, 4'b1110, 4'b0101, 4'b0101,
                             4'b1001, 4'b1000};
    logic [9:0] obs, ex;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i][3], tbl[i][2], tbl[i][1], tbl[i][0], 3);
      model_step(tbl[i][3], tbl[i][2], tbl[i][1], tbl[i][0]);
      for (int c = 0; c < 60; c++) begin
        @(negedge Clock);
        obs = {Hsinc, Vsinc, Rojo, Verde, Azul};
        ex  = exp_out(n, hue_m, lvl_m);
        checks++;
        if (obs !== ex) begin
          errors++;
          $display("[TB] FAIL directed%0d n=%0d got=%b want=%b", i, n, obs, ex);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [3:0] b;
    logic [9:0] obs, ex;
    for (int i = 0; i < 30; i++) begin
      b = 4'($urandom_range(0, 15));
      applyStimulus(b[3], b[2], b[1], b[0], $urandom_range(3, 6));
      model_step(b[3], b[2], b[1], b[0]);
      for (int c = 0; c < 60; c++) begin
        @(negedge Clock);
        obs = {Hsinc, Vsinc, Rojo, Verde, Azul};
        ex  = exp_out(n, hue_m, lvl_m);
        checks++;
        if (obs !== ex) begin
          errors++;
          $display("[TB] FAIL random%0d n=%0d got=%b want=%b", i, n, obs, ex);
        end
      end
    end
  endtask

  task automatic test_midreset;
    logic [9:0] obs, ex;
    int p, guard;
    applyStimulus(0, 0, 0, 0, 3);
    if (lvl_m == 0) begin
      applyStimulus(1, 0, 0, 1, 3);
      model_step(1, 0, 0, 1);
    end
    guard = 0;
    do begin
      @(negedge Clock);
      p = ((n - 1) / 2) % FRAME;
      guard++;
    end while (!((p % HT) >= 4 && (p % HT) < 10 && (p / HT) < VV) && guard < 2000);
    checks++;
    if (guard >= 2000) begin
      errors++;
      $display("[TB] FAIL midreset_align got=timeout want=visible");
    end
    #3 reset = 0;
    #1 obs = {Hsinc, Vsinc, Rojo, Verde, Azul};
    checks++;
    if (obs !== 10'b11_000_000_00) begin
      errors++;
      $display("[TB] FAIL midreset_async got=%b want=%b", obs, 10'b11_000_000_00);
    end
    hue_m = 0;
    lvl_m = 3;
    repeat (2) @(negedge Clock);
    reset = 1;
    for (int c = 0; c < 120; c++) begin
      @(negedge Clock);
      obs = {Hsinc, Vsinc, Rojo, Verde, Azul};
      ex  = exp_out(n, hue_m, lvl_m);
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("[TB] FAIL after_reset n=%0d got=%b want=%b", n, obs, ex);
      end
    end
  endtask

  initial begin
    test_reset;
    test_frame;
    test_latency;
    test_hold;
    test_directed;
    test_random;
    test_midreset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
